// File: rtl/i2s_pkt_framer.sv
//------------------------------------------------------------------------------
// Module      : i2s_pkt_framer
// Description : Wraps tid-tagged per-channel I2S byte bursts in a 4-byte
//               transport header (sync, src/dst FPGA, channel, sequence) and
//               forwards them as an 8-bit AXI-stream.
//               Optional trailing XOR checksum: I2S_PKT_FRAMER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_pkt_framer #(
  parameter int         CN        = 16,
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  localparam int        IDW       = (CN > 1) ? $clog2(CN) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [IDW-1:0]    s_axis_tid,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic [3:0]        i_src_fpga_index,
  input  logic [4*CN-1:0]   i_dst_fpga_index,
  output logic [15:0]       o_trunc_count,
  output logic              o_busy
);

  localparam logic [7:0] c_len_last = 8'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_CSUM    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [IDW-1:0] r_ch;
  logic [3:0]     r_src;
  logic [3:0]     r_dst;
  logic [1:0]     r_hidx;
  logic [7:0]     r_hdr_byte;
  logic [7:0]     r_len;
  logic [15:0]    r_trunc_count;
  logic [7:0]     r_seq [CN];
  logic [3:0]     w_dst_sel;
  logic           w_len_last;
  logic           w_pay_xfer;

  assign w_dst_sel  = i_dst_fpga_index[{s_axis_tid, 2'b00} +: 4];
  assign w_len_last = (r_len == c_len_last);
  assign w_pay_xfer = (r_state == ST_PAYLOAD) && s_axis_tvalid && m_axis_tready;

  assign o_busy        = (r_state != ST_IDLE);
  assign o_trunc_count = r_trunc_count;

`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_trunc_pend;

  // Accumulator is cleared as the last header byte leaves, so it only covers payload.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_csum       <= 8'h00;
      r_trunc_pend <= 1'b0;
    end else if (r_state == ST_HDR && m_axis_tready && r_hidx == 2'd3) begin
      r_csum       <= 8'h00;
      r_trunc_pend <= 1'b0;
    end else if (w_pay_xfer) begin
      r_csum <= r_csum ^ s_axis_tdata;
      if (!s_axis_tlast && w_len_last) begin
        r_trunc_pend <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          w_next_state = ST_HDR;
        end
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_hdr_byte;
        if (m_axis_tready && r_hidx == 2'd3) begin
          w_next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
        m_axis_tlast  = 1'b0;
        if (w_pay_xfer && (s_axis_tlast || w_len_last)) begin
          w_next_state = ST_CSUM;
        end
`else
        m_axis_tlast  = s_axis_tlast | w_len_last;
        if (w_pay_xfer) begin
          if (s_axis_tlast) begin
            w_next_state = ST_IDLE;
          end else if (w_len_last) begin
            w_next_state = ST_DROP;
          end
        end
`endif
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_next_state = ST_IDLE;
        end
      end
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = r_csum;
        if (m_axis_tready) begin
          w_next_state = r_trunc_pend ? ST_DROP : ST_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Header byte is registered one step ahead so it stays stable under backpressure.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ch          <= '0;
      r_src         <= 4'h0;
      r_dst         <= 4'h0;
      r_hidx        <= 2'd0;
      r_hdr_byte    <= 8'h00;
      r_len         <= 8'h00;
      r_trunc_count <= 16'h0000;
      for (int i = 0; i < CN; i++) begin
        r_seq[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            r_ch       <= s_axis_tid;
            r_src      <= i_src_fpga_index;
            r_dst      <= w_dst_sel;
            r_hidx     <= 2'd0;
            r_hdr_byte <= SYNC_BYTE;
          end
        end
        ST_HDR: begin
          if (m_axis_tready) begin
            r_hidx <= r_hidx + 2'd1;
            case (r_hidx)
              2'd0: r_hdr_byte <= {r_src, r_dst};
              2'd1: r_hdr_byte <= 8'(r_ch);
              2'd2: r_hdr_byte <= r_seq[r_ch];
              default: begin
                r_seq[r_ch] <= r_seq[r_ch] + 8'd1;
                r_len       <= 8'h00;
              end
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (w_pay_xfer) begin
            r_len <= r_len + 8'd1;
            if (!s_axis_tlast && w_len_last && r_trunc_count != 16'hFFFF) begin
              r_trunc_count <= r_trunc_count + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_pkt_framer.sv
// Bench for i2s_pkt_framer: packet-level model of header/payload/truncation
// rules checked on every output transfer, plus literal packet expectations.
`default_nettype none

module tb_i2s_pkt_framer;
  localparam int         CN      = 16;
  localparam int         MAX_LEN = 4;
  localparam int         IDW     = 4;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      s_tdata = 8'h00;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            s_tlast = 1'b0;
  logic [IDW-1:0]  s_tid = '0;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [3:0]      src = 4'h1;
  logic [4*CN-1:0] dst = '0;
  logic [15:0]     trunc_count;
  logic            busy;

  i2s_pkt_framer #(.CN(CN), .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC)) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tlast     (s_tlast),
    .s_axis_tid       (s_tid),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tlast     (m_tlast),
    .i_src_fpga_index (src),
    .i_dst_fpga_index (dst),
    .o_trunc_count    (trunc_count),
    .o_busy           (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] lit[$];
  logic [7:0] pay[$];
  logic [7:0] seq_m[CN];
  int         trunc_m = 0;
  bit         bp_mode = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  // Whole-packet model: header, first min(n,MAX_LEN) bytes, optional XOR trailer.
  function automatic void model_pkt(input int ch);
    int         n = pay.size();
    int         nfwd = (n > MAX_LEN) ? MAX_LEN : n;
    logic [7:0] cs = 8'h00;
    exp_q.push_back({SYNC, 1'b0});
    exp_q.push_back({src, dst[4*ch +: 4], 1'b0});
    exp_q.push_back({8'(ch), 1'b0});
    exp_q.push_back({seq_m[ch], 1'b0});
    for (int i = 0; i < nfwd; i++) begin
      cs = cs ^ pay[i];
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
      exp_q.push_back({pay[i], 1'b0});
`else
      exp_q.push_back({pay[i], i == nfwd - 1});
`endif
    end
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    exp_q.push_back({cs, 1'b1});
`endif
    if (n > MAX_LEN) trunc_m++;
    seq_m[ch] = seq_m[ch] + 8'd1;
  endfunction

  // Compare process: every output transfer against the model, plus hold/latency rules.
  logic       prev_stall = 1'b0;
  logic       prev_cap = 1'b0;
  logic [8:0] prev_out = '0;
  always @(negedge sys_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_cap   = 1'b0;
    end else begin
      if (prev_cap) check("hdr_latency", {m_tvalid, m_tdata}, {1'b1, SYNC});
      if (prev_stall) check("stall_hold", {m_tvalid, m_tdata, m_tlast}, {1'b1, prev_out});
      if (m_tvalid && exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: actual data %0h with no byte required", m_tdata);
      end else if (m_tvalid && m_tready) begin
        check("out_byte", {m_tdata, m_tlast}, exp_q.pop_front());
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tlast};
      prev_cap   = !busy && s_tvalid;
    end
  end

  always @(posedge sys_clk) begin
    #1;
    m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic drive_burst(input int ch);
    bit ok;
    for (int i = 0; i < pay.size(); i++) begin
      s_tid    = ch[IDW-1:0];
      s_tdata  = pay[i];
      s_tlast  = (i == pay.size() - 1);
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge sys_clk);
        ok = s_tready;
      end
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL input_timeout: actual ready 0 required 1 for byte %0d", i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge sys_clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge sys_clk);
      done = (exp_q.size() == 0) && !busy;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d bytes pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input int ch);
    got_d.delete();
    got_l.delete();
    model_pkt(ch);
    drive_burst(ch);
    wait_idle();
  endtask

  task automatic set_pay(input logic [63:0] v, input int n);
    pay.delete();
    for (int i = n - 1; i >= 0; i--) pay.push_back(v[8*i +: 8]);
  endtask

  task automatic set_lit(input logic [63:0] v, input int n);
    lit.delete();
    for (int i = n - 1; i >= 0; i--) lit.push_back(v[8*i +: 8]);
  endtask

  task automatic check_got(input string name);
    check({name, "_len"}, got_d.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_d.size(); i++) begin
      check(name, {got_d[i], got_l[i]}, {lit[i], i == lit.size() - 1});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CN; i++) seq_m[i] = 8'h00;
    dst[4*3 +: 4] = 4'h2;
    dst[4*0 +: 4] = 4'h7;
    dst[4*5 +: 4] = 4'h9;
    dst[4*6 +: 4] = 4'hA;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    @(negedge sys_clk);
    check("reset_outputs", {m_tvalid, m_tlast, s_tready, busy, m_tdata}, 12'h000);
    check("reset_trunc", trunc_count, 16'h0000);

    // Basic packet; MAX_LEN is 4 so this is also the exact-length case.
    set_pay(64'h11223344, 4);
    send(3);
    set_lit(64'hA512030011223344, 8);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h44);
`endif
    check_got("basic_pkt");
    check("exact_len_no_trunc", trunc_count, 16'h0000);
    send(3);
    set_lit(64'hA512030111223344, 8);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h44);
`endif
    check_got("repeat_pkt");

    bp_mode = 1'b1;
    send(3);
    bp_mode = 1'b0;
    set_lit(64'hA512030211223344, 8);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h44);
`endif
    check_got("backpressure_pkt");

    // Truncation: 6-byte burst, only 4 forwarded.
    set_pay(64'h010203040506, 6);
    send(0);
    set_lit(64'hA517000001020304, 8);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h04);
`endif
    check_got("trunc_pkt");
    check("trunc_count", trunc_count, 16'h0001);
    set_pay(64'h5A, 1);
    send(0);
    set_lit(64'hA51700015A, 5);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h5A);
`endif
    check_got("after_trunc_seq");

    // Sequence wrap on ch5 with one ch6 packet interleaved.
    for (int i = 0; i < 256; i++) begin
      set_pay(64'(i), 1);
      send(5);
      if (i == 255) check("ch5_seq_ff", got_d.size() > 3 ? got_d[3] : 8'hxx, 8'hFF);
      if (i == 100) begin
        set_pay(64'h66, 1);
        send(6);
        check("ch6_seq", got_d.size() > 3 ? got_d[3] : 8'hxx, 8'h00);
      end
    end
    set_pay(64'h77, 1);
    send(5);
    check("ch5_seq_wrap", got_d.size() > 3 ? got_d[3] : 8'hxx, 8'h00);

    // Reset after two header bytes of a ch3 packet.
    got_d.delete();
    got_l.delete();
    set_pay(64'hEE, 1);
    model_pkt(3);
    s_tid    = 4'd3;
    s_tdata  = 8'hEE;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("abort_hdr_bytes", got_d.size(), 2);
    exp_q.delete();
    for (int i = 0; i < CN; i++) seq_m[i] = 8'h00;
    trunc_m = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("abort_outputs", {m_tvalid, m_tlast, s_tready, busy, m_tdata}, 12'h000);
    check("abort_trunc", trunc_count, 16'h0000);
    @(posedge sys_clk);
    #1 rst = 1'b0;
    set_pay(64'h010204, 3);
    send(3);
    set_lit(64'hA5120300010204, 7);
`ifdef I2S_PKT_FRAMER_CHECKSUM_EN
    lit.push_back(8'h07);
`endif
    check_got("post_reset_pkt");
    check("final_trunc", trunc_count, 16'(trunc_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
